// File: rtl/core_msg_rx_pkg.sv
// Shared definitions for the per-core message receive stage: FSM state
// encoding, decode of the scheduler loading-flag combination and the
// scheduler message bus width.
package gpu_def;

  localparam int SCHED_MSG_BUS_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MASK   = 3'd1,
    ST_R0     = 3'd2,
    ST_IFETCH = 3'd3,
    ST_EXEC   = 3'd4
  } rx_state_e;

  typedef enum logic [2:0] {
    MSG_NONE   = 3'd0,  // no message this cycle
    MSG_INSTR  = 3'd1,  // message with no loading flag
    MSG_CMASK  = 3'd2,  // task core mask
    MSG_R0MASK = 3'd3,  // r0-init mask
    MSG_R0DATA = 3'd4,  // r0 data word
    MSG_MULTI  = 3'd5   // more than one flag: protocol error, dropped
  } msg_kind_e;

  function automatic msg_kind_e msg_decode(input logic valid, input logic cm,
                                           input logic rm, input logic rd);
    msg_kind_e kind;
    if (!valid) begin
      kind = MSG_NONE;
    end else begin
      case ({cm, rm, rd})
        3'b000:  kind = MSG_INSTR;
        3'b100:  kind = MSG_CMASK;
        3'b010:  kind = MSG_R0MASK;
        3'b001:  kind = MSG_R0DATA;
        default: kind = MSG_MULTI;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/core_msg_rx_if.sv
// Scheduler-to-core receive bus: broadcast message word with its qualifier
// flags, the completion pulse, buffer read ports and status outputs.
// master = scheduler/core side, slave = core_msg_rx.
interface core_msg_rx_if #(
  parameter int INSTR_SIZE = 16,
  parameter int R0_DEPTH   = 13,
  parameter int IBUF_DEPTH = 64
);
  localparam int R0_AW = $clog2(R0_DEPTH);
  localparam int IB_AW = $clog2(IBUF_DEPTH);

  logic                  msg_valid;
  logic [INSTR_SIZE-1:0] mess_to_core;
  logic                  core_mask_loading;
  logic                  r0_mask_loading;
  logic                  r0_loading;
  logic                  exec_done;
  logic [R0_AW-1:0]      r0_rd_addr;
  logic [INSTR_SIZE-1:0] r0_rd_data;
  logic [IB_AW-1:0]      ibuf_rd_addr;
  logic [INSTR_SIZE-1:0] ibuf_rd_data;
  logic [IB_AW:0]        ibuf_count;
  logic [R0_AW:0]        r0_count;
  logic                  r0_init;
  logic                  exec_start;
  logic                  core_ready;
  logic                  proto_err;

  modport master (
    output msg_valid, mess_to_core, core_mask_loading, r0_mask_loading,
           r0_loading, exec_done, r0_rd_addr, ibuf_rd_addr,
    input  r0_rd_data, ibuf_rd_data, ibuf_count, r0_count, r0_init,
           exec_start, core_ready, proto_err
  );

  modport slave (
    input  msg_valid, mess_to_core, core_mask_loading, r0_mask_loading,
           r0_loading, exec_done, r0_rd_addr, ibuf_rd_addr,
    output r0_rd_data, ibuf_rd_data, ibuf_count, r0_count, r0_init,
           exec_start, core_ready, proto_err
  );
endinterface

// File: rtl/core_msg_buf.sv
// Small register file filled in order through a saturating write pointer.
// The pointer doubles as the valid-word count; reads at or beyond the count
// return zero. Storage is deliberately left unreset.
module core_msg_buf #(
  parameter int DEPTH = 13,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clr,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             w_wr_ok;

  assign w_wr_ok = i_wr_en && !i_clr && (r_count < FULL);

  // write pointer / count: cleared on task start, saturates at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {CW{1'b0}};
    end else if (i_clr) begin
      r_count <= {CW{1'b0}};
    end else if (w_wr_ok) begin
      r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  // storage write at the current pointer
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_count[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data = ({1'b0, i_rd_addr} < r_count) ? r_mem[i_rd_addr] : {WIDTH{1'b0}};
  assign o_count   = r_count;

endmodule

// File: rtl/core_msg_rx.sv
// Per-core receive stage downstream of the scheduler. Detects selection by
// the task core mask, captures the r0-init flag and r0 words, buffers the
// instruction stream, launches execution and holds core_ready low until the
// core reports completion.
// Optional feature macro CORE_RX_ERR_EN: when defined, proto_err is a sticky
// protocol-error flag; when undefined it is tied low (dropping and abort
// behaviour are unchanged).
module core_msg_rx
  import gpu_def::*;
#(
  parameter int CORE_ID    = 0,
  parameter int CORE_NUM   = 16,
  parameter int INSTR_SIZE = SCHED_MSG_BUS_WIDTH,
  parameter int R0_DEPTH   = 13,
  parameter int IBUF_DEPTH = 64
) (
  input logic           clk,
  input logic           reset,
  core_msg_rx_if.slave  bus
);
  localparam int R0_CW = $clog2(R0_DEPTH) + 1;
  localparam int IB_CW = $clog2(IBUF_DEPTH) + 1;
  localparam logic [R0_CW-1:0] R0_FULL = R0_CW'(R0_DEPTH);
  localparam logic [IB_CW-1:0] IB_LAST = IB_CW'(IBUF_DEPTH - 1);
`ifdef CORE_RX_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  rx_state_e r_state, w_state_nxt;
  msg_kind_e w_kind;
  logic      w_sel, w_clr, w_r0_wr, w_ib_wr, w_err_set;
  logic      w_core_ready_nxt, w_r0_init_nxt, w_exec_start_nxt;
  logic      r_core_ready, r_r0_init, r_exec_start, r_proto_err;

  assign w_kind = msg_decode(bus.msg_valid, bus.core_mask_loading,
                             bus.r0_mask_loading, bus.r0_loading);
  // a core outside the mask width can never be selected
  assign w_sel  = (CORE_ID < CORE_NUM) ? bus.mess_to_core[CORE_ID] : 1'b0;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state, buffer write strobes and next values of the control outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_clr            = 1'b0;
    w_r0_wr          = 1'b0;
    w_ib_wr          = 1'b0;
    w_err_set        = (w_kind == MSG_MULTI);
    w_core_ready_nxt = r_core_ready;
    w_r0_init_nxt    = r_r0_init;
    if ((w_kind == MSG_CMASK) && (r_state != ST_EXEC)) begin
      // selection from IDLE, or abort of a task still being loaded
      w_err_set = (r_state != ST_IDLE);
      if (w_sel) begin
        w_state_nxt      = ST_MASK;
        w_clr            = 1'b1;
        w_core_ready_nxt = 1'b0;
      end else begin
        w_state_nxt      = ST_IDLE;
        w_core_ready_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        ST_MASK: begin
          if (w_kind == MSG_R0MASK) begin
            w_r0_init_nxt = w_sel;
            w_state_nxt   = ST_R0;
          end else begin
            w_state_nxt   = ST_MASK;
          end
        end
        ST_R0: begin
          if ((w_kind == MSG_R0DATA) && r_r0_init) begin
            if (bus.r0_count == R0_FULL) begin
              w_err_set = 1'b1;
            end else begin
              w_r0_wr   = 1'b1;
            end
          end else if (w_kind == MSG_INSTR) begin
            w_ib_wr     = 1'b1;
            w_state_nxt = ST_IFETCH;
          end else begin
            w_state_nxt = ST_R0;
          end
        end
        ST_IFETCH: begin
          if (!bus.msg_valid) begin
            w_state_nxt = ST_EXEC;
          end else if (w_kind == MSG_INSTR) begin
            w_ib_wr = 1'b1;
            if (bus.ibuf_count == IB_LAST) begin
              w_state_nxt = ST_EXEC;
            end else begin
              w_state_nxt = ST_IFETCH;
            end
          end else begin
            w_state_nxt = ST_IFETCH;
          end
        end
        ST_EXEC: begin
          if (bus.exec_done) begin
            w_state_nxt      = ST_IDLE;
            w_core_ready_nxt = 1'b1;
          end else begin
            w_state_nxt      = ST_EXEC;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
    w_exec_start_nxt = (r_state == ST_IFETCH) && (w_state_nxt == ST_EXEC);
  end

  // registered control/status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_ready <= 1'b1;
      r_r0_init    <= 1'b0;
      r_exec_start <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_core_ready <= w_core_ready_nxt;
      r_r0_init    <= w_r0_init_nxt;
      r_exec_start <= w_exec_start_nxt;
      r_proto_err  <= r_proto_err | (w_err_set & ERR_EN);
    end
  end

  core_msg_buf #(.DEPTH(R0_DEPTH), .WIDTH(INSTR_SIZE)) u_r0_buf (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_wr_en   (w_r0_wr),
    .i_wr_data (bus.mess_to_core),
    .i_rd_addr (bus.r0_rd_addr),
    .o_rd_data (bus.r0_rd_data),
    .o_count   (bus.r0_count)
  );

  core_msg_buf #(.DEPTH(IBUF_DEPTH), .WIDTH(INSTR_SIZE)) u_ibuf (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_wr_en   (w_ib_wr),
    .i_wr_data (bus.mess_to_core),
    .i_rd_addr (bus.ibuf_rd_addr),
    .o_rd_data (bus.ibuf_rd_data),
    .o_count   (bus.ibuf_count)
  );

  assign bus.r0_init    = r_r0_init;
  assign bus.exec_start = r_exec_start;
  assign bus.core_ready = r_core_ready;
  assign bus.proto_err  = r_proto_err;

endmodule
